// File: rtl/aes_round_ctrl_if.sv
// Control bus between the AES round controller and its datapath / SPI front end.
interface aes_round_ctrl_if;
  logic       load;
  logic       init_en;
  logic       round_en;
  logic       mc_bypass;
  logic [3:0] round;
  logic [7:0] rcon;
  logic       capture_en;
  logic       busy;
  logic       done;

  // Controller side: samples load, drives the datapath enables and status.
  modport master (
    input  load,
    output init_en, round_en, mc_bypass, round, rcon, capture_en, busy, done
  );

  // Datapath / host side.
  modport slave (
    output load,
    input  init_en, round_en, mc_bypass, round, rcon, capture_en, busy, done
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: INIT, then NR x (SBOX_LAT wait cycles + one update cycle).
module aes_round_ctrl #(
  parameter int unsigned NR       = 10,
  parameter int unsigned SBOX_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  aes_round_ctrl_if.master  bus
);

  localparam int unsigned RW = 4;
  localparam int unsigned KW = 8;
  localparam int unsigned WW = 2;

  typedef enum logic [2:0] {IDLE, INIT, SUB, UPD, DONE} state_e;

  state_e        state_q, state_d;
  logic          load_q;
  logic [RW-1:0] round_q, round_d;
  logic [KW-1:0] rcon_q, rcon_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          init_en_q, round_en_q, final_q, busy_q, done_q;
  logic          start_c;

  function automatic logic [KW-1:0] xtime(input logic [KW-1:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  assign start_c = load_q & ~bus.load;

  // Next-state, round counter, rcon and sbox wait counter.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d = INIT;
          round_d = '0;
          rcon_d  = 8'h01;
        end
      end
      INIT: begin
        if (bus.load) begin
          state_d = IDLE;
        end else begin
          state_d = SUB;
          round_d = RW'(1);
          rcon_d  = 8'h01;
          wait_d  = '0;
        end
      end
      SUB: begin
        if (bus.load) begin
          state_d = IDLE;
        end else if (wait_q == WW'(SBOX_LAT - 1)) begin
          state_d = UPD;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      UPD: begin
        if (bus.load) begin
          state_d = IDLE;
        end else if (round_q == RW'(NR)) begin
          state_d = DONE;
        end else begin
          state_d = SUB;
          round_d = round_q + RW'(1);
          rcon_d  = xtime(rcon_q);
          wait_d  = '0;
        end
      end
      DONE: begin
        if (bus.load) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counters; outputs registered from the next-state decode so they align with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      load_q     <= 1'b0;
      round_q    <= '0;
      rcon_q     <= 8'h01;
      wait_q     <= '0;
      init_en_q  <= 1'b0;
      round_en_q <= 1'b0;
      final_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_q     <= bus.load;
      round_q    <= round_d;
      rcon_q     <= rcon_d;
      wait_q     <= wait_d;
      init_en_q  <= (state_d == INIT);
      round_en_q <= (state_d == UPD);
      final_q    <= (state_d == UPD) && (round_d == RW'(NR));
      busy_q     <= (state_d == INIT) || (state_d == SUB) || (state_d == UPD);
      done_q     <= (state_d == DONE);
    end
  end

  assign bus.init_en    = init_en_q;
  assign bus.round_en   = round_en_q;
  assign bus.mc_bypass  = final_q;
  assign bus.capture_en = final_q;
  assign bus.round      = round_q;
  assign bus.rcon       = rcon_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: three parameterisations driven by one load/reset stream.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic load;
  bit   mdl_on = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  aes_round_ctrl_if if0 ();
  aes_round_ctrl_if if1 ();
  aes_round_ctrl_if if2 ();
  assign if0.load = load;
  assign if1.load = load;
  assign if2.load = load;

  aes_round_ctrl #(.NR(10), .SBOX_LAT(1)) u0 (.clk(clk), .reset(reset), .bus(if0));
  aes_round_ctrl #(.NR(10), .SBOX_LAT(2)) u1 (.clk(clk), .reset(reset), .bus(if1));
  aes_round_ctrl #(.NR(14), .SBOX_LAT(3)) u2 (.clk(clk), .reset(reset), .bus(if2));

  typedef struct packed {
    logic init_en;
    logic round_en;
    logic mc_bypass;
    logic capture_en;
    logic busy;
    logic done;
  } flags_t;

  flags_t f0, f1, f2;
  assign f0 = {if0.init_en, if0.round_en, if0.mc_bypass, if0.capture_en, if0.busy, if0.done};
  assign f1 = {if1.init_en, if1.round_en, if1.mc_bypass, if1.capture_en, if1.busy, if1.done};
  assign f2 = {if2.init_en, if2.round_en, if2.mc_bypass, if2.capture_en, if2.busy, if2.done};

  logic [7:0] rcon_tab [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d};

  // Reference: cycle offset d since start (1 = INIT); busy while d <= 1+NR*(LAT+1).
  typedef struct packed {
    logic       active;
    logic       done;
    logic       load_q;
    logic [7:0] d;
  } mdl_t;

  mdl_t m0, m1, m2;

  function automatic mdl_t mdl_step(mdl_t m, logic rst, logic ld, int nr, int lat);
    mdl_t n = m;
    if (rst) return '0;
    if (m.active) begin
      if (ld) n.active = 1'b0;
      else if (int'(m.d) == 1 + nr * (lat + 1)) begin
        n.active = 1'b0;
        n.done   = 1'b1;
      end else n.d = m.d + 8'd1;
    end else if (m.done) begin
      if (ld) n.done = 1'b0;
    end else if (m.load_q && !ld) begin
      n.active = 1'b1;
      n.d      = 8'd1;
    end
    n.load_q = ld;
    return n;
  endfunction

  function automatic flags_t mdl_flags(mdl_t m, int nr, int lat);
    flags_t f = '0;
    int d = int'(m.d);
    f.busy       = m.active;
    f.done       = m.done;
    f.init_en    = m.active && d == 1;
    f.round_en   = m.active && d > 1 && ((d - 1) % (lat + 1)) == 0;
    f.mc_bypass  = f.round_en && ((d - 1) / (lat + 1)) == nr;
    f.capture_en = f.mc_bypass;
    return f;
  endfunction

  function automatic int mdl_round(mdl_t m, int nr, int lat);
    int d = int'(m.d);
    if (m.done) return nr;
    if (!m.active || d <= 1) return 0;
    return (d - 1 + lat) / (lat + 1);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
    end
  endtask

  task automatic chk_inst(string nm, mdl_t m, int nr, int lat, flags_t af,
                          logic [3:0] ar, logic [7:0] ac);
    flags_t ef = mdl_flags(m, nr, lat);
    int k = mdl_round(m, nr, lat);
    chk({nm, "_flags"}, 32'(af), 32'(ef));
    if (m.active || m.done) chk({nm, "_round"}, 32'(ar), 32'(k));
    if (ef.round_en || m.done) chk({nm, "_rcon"}, 32'(ac), 32'(rcon_tab[k-1]));
  endtask

  // Reference model advances on the same edge as the DUTs.
  always @(posedge clk) begin
    m0 = mdl_step(m0, reset, load, 10, 1);
    m1 = mdl_step(m1, reset, load, 10, 2);
    m2 = mdl_step(m2, reset, load, 14, 3);
  end

  // Continuous model comparison, away from the active edge.
  always @(negedge clk) begin
    if (mdl_on) begin
      chk_inst("u0", m0, 10, 1, f0, if0.round, if0.rcon);
      chk_inst("u1", m1, 10, 2, f1, if1.round, if1.rcon);
      chk_inst("u2", m2, 14, 3, f2, if2.round, if2.rcon);
    end
  end

  typedef struct {
    int         ofs;
    flags_t     f;
    logic [3:0] rnd;
    logic [7:0] rc;
    bit         chk_rc;
  } vec_t;

  vec_t vec [16];

  task automatic start_run();
    load = 1'b1;
    repeat (3) @(negedge clk);
    load = 1'b0;
  endtask

  // Timeline after a load fall: table for u0, first-done cycle for u1/u2.
  task automatic run_check(string tag);
    for (int ofs = 1; ofs <= 60; ofs++) begin
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
        if (vec[i].ofs == ofs) begin
          chk($sformatf("%s_t%0d_flags", tag, ofs), 32'(f0), 32'(vec[i].f));
          chk($sformatf("%s_t%0d_round", tag, ofs), 32'(if0.round), 32'(vec[i].rnd));
          if (vec[i].chk_rc)
            chk($sformatf("%s_t%0d_rcon", tag, ofs), 32'(if0.rcon), 32'(vec[i].rc));
        end
      end
      if (ofs == 31) chk({tag, "_u1_done31"}, 32'(if1.done), 32'd0);
      if (ofs == 32) chk({tag, "_u1_done32"}, 32'(if1.done), 32'd1);
      if (ofs == 57) chk({tag, "_u2_done57"}, 32'(if2.done), 32'd0);
      if (ofs == 58) chk({tag, "_u2_done58"}, 32'(if2.done), 32'd1);
    end
  endtask

  initial begin
    // flags order: init_en, round_en, mc_bypass, capture_en, busy, done
    vec[0]  = '{1,  6'b100010, 4'd0,  8'h00, 1'b0};
    vec[1]  = '{2,  6'b000010, 4'd1,  8'h01, 1'b1};
    vec[2]  = '{3,  6'b010010, 4'd1,  8'h01, 1'b1};
    vec[3]  = '{4,  6'b000010, 4'd2,  8'h02, 1'b1};
    vec[4]  = '{5,  6'b010010, 4'd2,  8'h02, 1'b1};
    vec[5]  = '{7,  6'b010010, 4'd3,  8'h04, 1'b1};
    vec[6]  = '{9,  6'b010010, 4'd4,  8'h08, 1'b1};
    vec[7]  = '{11, 6'b010010, 4'd5,  8'h10, 1'b1};
    vec[8]  = '{13, 6'b010010, 4'd6,  8'h20, 1'b1};
    vec[9]  = '{15, 6'b010010, 4'd7,  8'h40, 1'b1};
    vec[10] = '{17, 6'b010010, 4'd8,  8'h80, 1'b1};
    vec[11] = '{19, 6'b010010, 4'd9,  8'h1b, 1'b1};
    vec[12] = '{20, 6'b000010, 4'd10, 8'h36, 1'b1};
    vec[13] = '{21, 6'b011110, 4'd10, 8'h36, 1'b1};
    vec[14] = '{22, 6'b000001, 4'd10, 8'h36, 1'b1};
    vec[15] = '{23, 6'b000001, 4'd10, 8'h36, 1'b1};

    reset = 1'b1;
    load  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_flags_u0", 32'(f0), 32'd0);
    chk("rst_flags_u2", 32'(f2), 32'd0);
    chk("rst_round_u0", 32'(if0.round), 32'd0);
    chk("rst_rcon_u0", 32'(if0.rcon), 32'h01);
    mdl_on = 1'b1;
    reset  = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_start_after_rst", 32'(if0.busy), 32'd0);

    // Full run at all three parameterisations.
    start_run();
    run_check("run1");

    // Abort in round 5 SUB, then a clean rerun.
    start_run();
    for (int ofs = 1; ofs <= 10; ofs++) @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(if0.busy), 32'd0);
    chk("abort_cap", 32'(if0.capture_en), 32'd0);
    chk("abort_done", 32'(if0.done), 32'd0);
    load = 1'b0;
    run_check("rerun");

    // Reset during round 7 UPD discards the run; idle with load low.
    start_run();
    for (int ofs = 1; ofs <= 15; ofs++) @(negedge clk);
    chk("pre_rst_upd", 32'(if0.round_en), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_flags", 32'(f0), 32'd0);
    chk("midrst_round", 32'(if0.round), 32'd0);
    chk("midrst_rcon", 32'(if0.rcon), 32'h01);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("midrst_idle", 32'(f0), 32'd0);

    // Done is sticky until load rises, then a second identical run.
    start_run();
    run_check("seq1");
    repeat (5) @(negedge clk);
    chk("done_sticky", 32'(if0.done), 32'd1);
    load = 1'b1;
    @(negedge clk);
    chk("done_clear", 32'(if0.done), 32'd0);
    load = 1'b0;
    run_check("seq2");

    // Randomized load activity with occasional reset.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) load = ~load;
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
